mfb_metadata_inserter: RTL

- Counterpart of the MFB metadata extractor: merges an MVB stream of per-frame metadata back onto an MFB frame stream.
- Each frame start (SOF) consumes exactly one MVB item, in arrival order, and presents it on TX_MFB_META of the SOF region.
- Sits in front of blocks that expect metadata riding on the MFB bus, such as the loopback path in the extractor verification.

---
 rtl/mfb_metadata_inserter.sv | 108 ++++++++++
 1 files changed

// File: rtl/mfb_metadata_inserter.sv
// mfb_metadata_inserter: merges MVB metadata onto MFB frames; define MFB_META_INSERT_EOF_EN to align metadata to EOF instead of SOF
module mfb_metadata_inserter #(
    parameter int MFB_REGIONS     = 4,
    parameter int MFB_REGION_SIZE = 8,
    parameter int MFB_BLOCK_SIZE  = 8,
    parameter int MFB_ITEM_WIDTH  = 8,
    parameter int MFB_META_WIDTH  = 16,
    parameter int MVB_ITEMS       = 4,
    parameter int FIFO_DEPTH      = 16,
    localparam int DW = MFB_REGIONS*MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH,
    localparam int SW = MFB_REGION_SIZE > 1 ? $clog2(MFB_REGION_SIZE) : 1,
    localparam int EW = MFB_REGION_SIZE*MFB_BLOCK_SIZE > 1 ? $clog2(MFB_REGION_SIZE*MFB_BLOCK_SIZE) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DW-1:0]                       rx_mfb_data,
    input  logic [MFB_REGIONS-1:0]              rx_mfb_sof,
    input  logic [MFB_REGIONS-1:0]              rx_mfb_eof,
    input  logic [MFB_REGIONS*SW-1:0]           rx_mfb_sof_pos,
    input  logic [MFB_REGIONS*EW-1:0]           rx_mfb_eof_pos,
    input  logic                                rx_mfb_src_rdy,
    output logic                                rx_mfb_dst_rdy,
    input  logic [MVB_ITEMS*MFB_META_WIDTH-1:0] rx_mvb_data,
    input  logic [MVB_ITEMS-1:0]                rx_mvb_vld,
    input  logic                                rx_mvb_src_rdy,
    output logic                                rx_mvb_dst_rdy,
    output logic [DW-1:0]                       tx_mfb_data,
    output logic [MFB_REGIONS-1:0]              tx_mfb_sof,
    output logic [MFB_REGIONS-1:0]              tx_mfb_eof,
    output logic [MFB_REGIONS*SW-1:0]           tx_mfb_sof_pos,
    output logic [MFB_REGIONS*EW-1:0]           tx_mfb_eof_pos,
    output logic [MFB_REGIONS*MFB_META_WIDTH-1:0] tx_mfb_meta,
    output logic                                tx_mfb_src_rdy,
    input  logic                                tx_mfb_dst_rdy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [MFB_META_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, need, wn;
    logic [MFB_REGIONS-1:0] sel;
    logic [AW-1:0] wofs [MVB_ITEMS];
    logic [MFB_REGIONS-1:0][MFB_META_WIDTH-1:0] meta_n;
    logic out_free, mvb_go, mfb_go;

`ifdef MFB_META_INSERT_EOF_EN
    assign sel = rx_mfb_eof;
`else
    assign sel = rx_mfb_sof;
`endif

    assign need           = CW'($countones(sel));
    assign wn             = CW'($countones(rx_mvb_vld));
    assign out_free       = !tx_mfb_src_rdy || tx_mfb_dst_rdy;
    assign rx_mfb_dst_rdy = !reset && out_free && (cnt >= need);
    assign rx_mvb_dst_rdy = !reset && (FIFO_DEPTH - int'(cnt) >= MVB_ITEMS);
    assign mvb_go         = rx_mvb_src_rdy && rx_mvb_dst_rdy;
    assign mfb_go         = rx_mfb_src_rdy && rx_mfb_dst_rdy;

    // each valid MVB item lands after the valid items below it (compaction)
    for (genvar i = 0; i < MVB_ITEMS; i++) begin : g_wofs
        assign wofs[i] = AW'($countones(rx_mvb_vld & MVB_ITEMS'((1 << i) - 1)));
    end

    // the k-th selected region reads FIFO entry rd_ptr+k; others get zero
    for (genvar r = 0; r < MFB_REGIONS; r++) begin : g_meta
        assign meta_n[r] = sel[r] ? mem[rd_ptr + AW'($countones(sel & MFB_REGIONS'((1 << r) - 1)))] : '0;
    end

    // metadata storage, no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (mvb_go)
            for (int i = 0; i < MVB_ITEMS; i++)
                if (rx_mvb_vld[i]) mem[wr_ptr + wofs[i]] <= rx_mvb_data[i*MFB_META_WIDTH +: MFB_META_WIDTH];
    end

    // FIFO pointers/count and the registered TX word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cnt            <= '0;
            tx_mfb_data    <= '0;
            tx_mfb_sof     <= '0;
            tx_mfb_eof     <= '0;
            tx_mfb_sof_pos <= '0;
            tx_mfb_eof_pos <= '0;
            tx_mfb_meta    <= '0;
            tx_mfb_src_rdy <= 1'b0;
        end else begin
            if (mvb_go) wr_ptr <= wr_ptr + AW'(wn);
            if (mfb_go) rd_ptr <= rd_ptr + AW'(need);
            cnt <= cnt + (mvb_go ? wn : '0) - (mfb_go ? need : '0);
            if (mfb_go) begin
                tx_mfb_data    <= rx_mfb_data;
                tx_mfb_sof     <= rx_mfb_sof;
                tx_mfb_eof     <= rx_mfb_eof;
                tx_mfb_sof_pos <= rx_mfb_sof_pos;
                tx_mfb_eof_pos <= rx_mfb_eof_pos;
                tx_mfb_meta    <= meta_n;
                tx_mfb_src_rdy <= 1'b1;
            end else if (tx_mfb_dst_rdy) begin
                tx_mfb_src_rdy <= 1'b0;
            end
        end
    end
endmodule
